// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the req/ack responder and the
// initiator-side formal harness: FSM state enum, latency/gap defaults, counter width.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } state_t;

  localparam int ACK_LATENCY_DEF = 4;
  localparam int MIN_GAP_DEF     = 8;
  localparam int CNT_BITS        = 5;

  typedef logic [CNT_BITS-1:0] cnt_t;

endpackage

// File: rtl/req_ack_responder.sv
// Responder: acks each legal req after ACK_LATENCY cycles, enforces MIN_GAP.
// Ports: clk, rst_n (async low), req in; ack, busy, proto_err, ack_count out.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int ACK_LATENCY = ACK_LATENCY_DEF,
  parameter int MIN_GAP     = MIN_GAP_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             ack,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] ack_count
);

  // HOLD spans the cycles after the ack up to the end of the gap window.
  localparam int   HOLD_CYC = MIN_GAP - ACK_LATENCY - 1;
  localparam cnt_t WAIT_LD  = cnt_t'(ACK_LATENCY - 2);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);

  state_t state;
  cnt_t   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      ack_count <= '0;
    end else begin
      ack <= 1'b0;
      if (ack)
        ack_count <= ack_count + CNT_W'(1);
      if (req && state != IDLE)
        proto_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (req) begin
            state <= WAIT;
            cnt   <= WAIT_LD;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= ACK;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        ACK: begin
          // A gap of exactly ACK_LATENCY+1 leaves no hold cycles.
          if (HOLD_CYC == 0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= HOLD;
            cnt   <= HOLD_LD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
      endcase
    end
  end

`ifdef FORMAL
  logic acc;
  assign acc = req && state == IDLE;

  a_ack_lat: assert property (
    @(posedge clk) disable iff (!rst_n)
    acc |-> ##ACK_LATENCY ack);

  a_no_spur: assert property (
    @(posedge clk) disable iff (!rst_n)
    ack |-> $past(acc, ACK_LATENCY));

  a_pulse: assert property (
    @(posedge clk) disable iff (!rst_n)
    ack |=> !ack);
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Randomized + directed bench for req_ack_responder against a
// cycle-age reference model; prints one CHECKS/ERRORS summary.
module tb_req_ack_responder;

  localparam int L  = 4;
  localparam int MG = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          ack;
  logic          busy;
  logic          proto_err;
  logic [CW-1:0] ack_count;

  req_ack_responder #(
    .ACK_LATENCY(L),
    .MIN_GAP    (MG),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .busy     (busy),
    .proto_err(proto_err),
    .ack_count(ack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: age = cycles since the last accepted req (saturating).
  int            age;
  logic          m_err;
  logic [CW-1:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age   <= 1000;
      m_err <= 1'b0;
      m_cnt <= '0;
    end else begin
      if (age == L)
        m_cnt <= m_cnt + 1'b1;
      if (req && age >= 1 && age <= MG - 1)
        m_err <= 1'b1;
      if (req && age >= MG)
        age <= 1;
      else if (age < 1000)
        age <= age + 1;
    end
  end

  int checks;
  int errors;
  int rel;

  logic h_ack [0:63];
  logic h_busy[0:63];
  logic h_err [0:63];
  int   h_cnt [0:63];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s rel=%0d got %0d want %0d", nm, rel, got, exp);
    end
  endtask

  task automatic step(input logic r, input bit lo, input bit hi);
    @(negedge clk);
    chk("ack", {31'd0, ack}, {31'd0, (age == L)});
    chk("busy", {31'd0, busy},
        {31'd0, (age >= 1 && age <= MG - 1)});
    chk("proto_err", {31'd0, proto_err}, {31'd0, m_err});
    chk("ack_count", 32'(ack_count), 32'(m_cnt));
    if (rel < 64) begin
      h_ack[rel]  = ack;
      h_busy[rel] = busy;
      h_err[rel]  = proto_err;
      h_cnt[rel]  = int'(ack_count);
    end
    req = r;
    if (lo) begin
      #2 rst_n = 1'b0;
    end
    if (hi) begin
      #2 rst_n = 1'b1;
    end
    rel++;
  endtask

  task automatic apply_reset();
    req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run(input logic [63:0] pat, input int n,
                     input int rst_at);
    apply_reset();
    rel = 0;
    for (int c = 0; c < n; c++)
      step(pat[c], c == rst_at, c == rst_at + 1);
    req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rel    = 0;
    req    = 1'b0;
    rst_n  = 1'b0;
    #12;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, proto_err}, 32'd0);
    chk("rst_cnt", 32'(ack_count), 32'd0);

    // single req at 10
    run(64'h400, 24, -1);
    chk("s1_ack13", {31'd0, h_ack[13]}, 32'd0);
    chk("s1_ack14", {31'd0, h_ack[14]}, 32'd1);
    chk("s1_ack15", {31'd0, h_ack[15]}, 32'd0);
    chk("s1_busy10", {31'd0, h_busy[10]}, 32'd0);
    chk("s1_busy11", {31'd0, h_busy[11]}, 32'd1);
    chk("s1_busy17", {31'd0, h_busy[17]}, 32'd1);
    chk("s1_busy18", {31'd0, h_busy[18]}, 32'd0);
    chk("s1_cnt14", 32'(h_cnt[14]), 32'd0);
    chk("s1_cnt15", 32'(h_cnt[15]), 32'd1);
    chk("s1_err", {31'd0, h_err[23]}, 32'd0);

    // reqs at 10 and 18 (first legal idle cycle)
    run((64'd1 << 10) | (64'd1 << 18), 26, -1);
    chk("s2_ack14", {31'd0, h_ack[14]}, 32'd1);
    chk("s2_ack22", {31'd0, h_ack[22]}, 32'd1);
    chk("s2_err", {31'd0, h_err[25]}, 32'd0);
    chk("s2_cnt", 32'(h_cnt[23]), 32'd2);

    // reqs at 10, 13 (violation), 20
    run((64'd1 << 10) | (64'd1 << 13) | (64'd1 << 20), 28, -1);
    chk("s3_ack14", {31'd0, h_ack[14]}, 32'd1);
    chk("s3_ack17", {31'd0, h_ack[17]}, 32'd0);
    chk("s3_err13", {31'd0, h_err[13]}, 32'd0);
    chk("s3_err14", {31'd0, h_err[14]}, 32'd1);
    chk("s3_cnt19", 32'(h_cnt[19]), 32'd1);
    chk("s3_ack24", {31'd0, h_ack[24]}, 32'd1);
    chk("s3_err27", {31'd0, h_err[27]}, 32'd1);

    // req held 10..12
    run(64'h1C00, 22, -1);
    chk("s4_ack14", {31'd0, h_ack[14]}, 32'd1);
    chk("s4_ack15", {31'd0, h_ack[15]}, 32'd0);
    chk("s4_err11", {31'd0, h_err[11]}, 32'd0);
    chk("s4_err12", {31'd0, h_err[12]}, 32'd1);
    chk("s4_cnt", 32'(h_cnt[20]), 32'd1);

    // req at final HOLD cycle (17) is a violation
    run((64'd1 << 10) | (64'd1 << 17), 30, -1);
    chk("s5_err18", {31'd0, h_err[18]}, 32'd1);
    chk("s5_ack21", {31'd0, h_ack[21]}, 32'd0);
    chk("s5_cnt", 32'(h_cnt[29]), 32'd1);

    // reset mid-flight at 12, released at 13, req at 13
    run((64'd1 << 10) | (64'd1 << 13), 22, 12);
    chk("s6_busy13", {31'd0, h_busy[13]}, 32'd0);
    chk("s6_cnt13", 32'(h_cnt[13]), 32'd0);
    chk("s6_ack14", {31'd0, h_ack[14]}, 32'd0);
    chk("s6_ack16", {31'd0, h_ack[16]}, 32'd0);
    chk("s6_ack17", {31'd0, h_ack[17]}, 32'd1);
    chk("s6_err", {31'd0, h_err[20]}, 32'd0);

    // count wrap with CNT_W=2
    run((64'd1 << 0) | (64'd1 << 8) | (64'd1 << 16) |
        (64'd1 << 24) | (64'd1 << 32), 40, -1);
    chk("s7_c5", 32'(h_cnt[5]), 32'd1);
    chk("s7_c13", 32'(h_cnt[13]), 32'd2);
    chk("s7_c21", 32'(h_cnt[21]), 32'd3);
    chk("s7_c29", 32'(h_cnt[29]), 32'd0);
    chk("s7_c37", 32'(h_cnt[37]), 32'd1);

    // random traffic with occasional resets
    apply_reset();
    rel = 64;
    begin
      bit pend_hi;
      pend_hi = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit lo;
        lo = !pend_hi && ($urandom_range(0, 499) == 0);
        step($urandom_range(0, 5) == 0, lo, pend_hi);
        pend_hi = lo;
      end
      if (pend_hi)
        step(1'b0, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
